// File: rtl/flag_request_queue.sv
// Event queue ahead of a flag/busy crossing: counts events and replays each as a one-cycle flag only while the crossing is idle.
// Latency: event to flag_out is 2 cycles from idle; optional saturating drop counter under FLAG_REQUEST_QUEUE_DROP_CNT_EN.
// Backpressure: busy_in stalls issue; up to 2^CNT_W-1 events held, further events dropped and reported via overflow.
module flag_request_queue #(
    parameter int CNT_W        = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_in,
    input  logic             busy_in,
    input  logic             clr_err,
    output logic             flag_out,
    output logic [CNT_W-1:0] pending,
    output logic             idle,
    output logic             overflow,
    output logic             timeout_err
`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    localparam logic [15:0] TOUT = 16'(BUSY_TIMEOUT);

    state_t      stateQ, stateD;
    logic [15:0] waitCnt, waitCntD;
    logic        toutHit;
    logic        decPend, dropEv, incPend;

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCnt;
        toutHit  = 1'b0;
        case (stateQ)
            IDLE: begin
                if (pending != '0 && !busy_in) begin
                    stateD   = ISSUE;
                    waitCntD = '0;
                end
            end
            ISSUE: stateD = WAIT_HI;
            WAIT_HI: begin
                if (busy_in) begin
                    stateD = WAIT_LO;
                end else if (waitCnt + 16'd1 == TOUT) begin
                    toutHit = 1'b1;
                    stateD  = IDLE;
                end else begin
                    waitCntD = waitCnt + 16'd1;
                end
            end
            WAIT_LO: begin
                if (!busy_in) begin
                    stateD = IDLE;
                end else if (waitCnt + 16'd1 == TOUT) begin
                    toutHit = 1'b1;
                    stateD  = IDLE;
                end else begin
                    waitCntD = waitCnt + 16'd1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // A full queue still accepts an event when the same cycle drains one.
    assign decPend = (stateQ == ISSUE);
    assign dropEv  = event_in && (pending == '1) && !decPend;
    assign incPend = event_in && !dropEv;
    assign idle    = (stateQ == IDLE) && (pending == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= IDLE;
            waitCnt     <= '0;
            pending     <= '0;
            flag_out    <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            stateQ   <= stateD;
            waitCnt  <= waitCntD;
            flag_out <= (stateD == ISSUE);
            if (incPend && !decPend)
                pending <= pending + CNT_W'(1);
            else if (!incPend && decPend)
                pending <= pending - CNT_W'(1);
            if (dropEv)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (toutHit)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
        end
    end

`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (clr_err)
            drop_cnt <= dropEv ? 16'd1 : 16'd0;
        else if (dropEv && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_flag_request_queue.sv
// Randomized and directed bench for flag_request_queue against a handshake-level reference model.
module tb_flag_request_queue;
    localparam int CNT_W = 4;
    localparam int TOUT  = 8;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b1, event_in = 1'b0, busy_in = 1'b0, clr_err = 1'b0;
    logic flag_out, idle, overflow, timeout_err;
    logic [CNT_W-1:0] pending;
`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    flag_request_queue #(.CNT_W(CNT_W), .BUSY_TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .event_in(event_in), .busy_in(busy_in), .clr_err(clr_err),
        .flag_out(flag_out), .pending(pending), .idle(idle),
        .overflow(overflow), .timeout_err(timeout_err)
`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0, nPass = 0;

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: queue depth plus the progress of the current handshake.
    int mPend, mStuck, mDrop;
    bit mHs, mSaw, mFlag, mOvf, mTerr;
    bit mDec, mDropEv, mTev, mStart, mMet;

    always @(posedge clk) begin
        if (rst) begin
            mPend = 0; mStuck = 0; mDrop = 0;
            mHs = 0; mSaw = 0; mFlag = 0; mOvf = 0; mTerr = 0;
        end else begin
            mDec    = mFlag;
            mDropEv = event_in && (mPend == MAXP) && !mDec;
            mTev    = 0;
            mStart  = 0;
            if (mHs && !mFlag) begin
                mMet = mSaw ? !busy_in : busy_in;
                if (mMet) begin
                    if (mSaw) mHs = 0; else mSaw = 1;
                end else begin
                    mStuck++;
                    if (mStuck == TOUT) begin mTev = 1; mHs = 0; end
                end
            end else if (!mHs && mPend != 0 && !busy_in) begin
                mStart = 1;
            end
            if (mStart) begin mHs = 1; mSaw = 0; mStuck = 0; end
            mFlag = mStart;
            mPend = mPend + ((event_in && !mDropEv) ? 1 : 0) - (mDec ? 1 : 0);
            mOvf  = mDropEv ? 1'b1 : (clr_err ? 1'b0 : mOvf);
            mTerr = mTev ? 1'b1 : (clr_err ? 1'b0 : mTerr);
            if (clr_err) mDrop = mDropEv ? 1 : 0;
            else if (mDropEv && mDrop < 65535) mDrop++;
        end
    end

    bit chkOn = 0, countOn = 0;
    int nFlags, nViol, peak;

    always @(negedge clk) begin
        if (chkOn) begin
            checkVal("flag_out", flag_out, mFlag);
            checkVal("pending", pending, mPend);
            checkVal("idle", idle, (!mHs && mPend == 0) ? 1 : 0);
            checkVal("overflow", overflow, mOvf);
            checkVal("timeout_err", timeout_err, mTerr);
`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
            checkVal("drop_cnt", drop_cnt, mDrop);
`endif
        end
        if (countOn) begin
            if (flag_out) nFlags++;
            if (flag_out && busy_in) nViol++;
            if (pending > peak) peak = pending;
        end
    end

    // Crossing emulation: busy rises the cycle after a flag and stays high busyLen cycles (0 = random).
    int busyLeft = 0, busyLen = 6;
    bit forceBusy = 0;

    task automatic tick();
        @(posedge clk); #1;
        event_in = 0; clr_err = 0; rst = 0;
        if (busyLeft > 0) begin busy_in = 1; busyLeft--; end
        else busy_in = forceBusy;
        if (flag_out) busyLeft = (busyLen == 0) ? $urandom_range(1, 11) : busyLen;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (!(idle && busyLeft == 0 && !busy_in) && n < budget) begin tick(); n++; end
        if (n >= budget) checkVal({tag, "_wait_expired"}, 0, 1);
    endtask

    task automatic waitFlag(input string tag, input int budget);
        int n = 0;
        while (!flag_out && n < budget) begin tick(); n++; end
        if (n >= budget) checkVal({tag, "_wait_expired"}, 0, 1);
    endtask

    function automatic bit willTimeout();
        return mHs && !mFlag && (mSaw ? busy_in : !busy_in) && (mStuck + 1 == TOUT);
    endfunction

    initial begin
        int n, bad;
        rst = 1;
        tick();
        chkOn = 1;
        checkVal("reset_pending", pending, 0);
        checkVal("reset_idle", idle, 1);
        checkVal("reset_flag", flag_out, 0);

        // Single event, busy held 6 cycles after accept
        busyLen = 6;
        event_in = 1; tick();
        checkVal("single_pend_c1", pending, 1);
        checkVal("single_flag_c1", flag_out, 0);
        tick();
        checkVal("single_flag_c2", flag_out, 1);
        tick();
        checkVal("single_flag_c3", flag_out, 0);
        checkVal("single_pend_c3", pending, 0);
        n = 0;
        while (busy_in && n < 20) begin tick(); n++; end
        checkVal("single_idle_busyfall", idle, 0);
        tick();
        checkVal("single_idle_after", idle, 1);

        // Burst of 5 while the crossing is busy, then drain
        nFlags = 0; nViol = 0; peak = 0; countOn = 1;
        forceBusy = 1; tick();
        for (int i = 0; i < 5; i++) begin event_in = 1; tick(); end
        forceBusy = 0; tick();
        waitIdle("burst", 200);
        countOn = 0;
        checkVal("burst_peak", peak, 5);
        checkVal("burst_flags", nFlags, 5);
        checkVal("burst_flag_while_busy", nViol, 0);
        checkVal("burst_final_pend", pending, 0);
        checkVal("burst_overflow", overflow, 0);

        // Overfill: 17 events with busy high
        forceBusy = 1; tick();
        for (int i = 0; i < 17; i++) begin event_in = 1; tick(); end
        checkVal("ovf_pending", pending, 15);
        checkVal("ovf_flag", overflow, 1);
`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
        checkVal("ovf_drop_cnt", drop_cnt, 2);
`endif
        clr_err = 1; tick();
        checkVal("ovf_cleared", overflow, 0);
`ifdef FLAG_REQUEST_QUEUE_DROP_CNT_EN
        checkVal("ovf_drop_cleared", drop_cnt, 0);
`endif
        forceBusy = 0; tick();
        waitIdle("ovf_drain", 400);

        // Event coincident with ISSUE, pending=3
        forceBusy = 1; tick();
        for (int i = 0; i < 3; i++) begin event_in = 1; tick(); end
        forceBusy = 0; tick();
        waitFlag("coinc", 20);
        checkVal("coinc_pend_issue", pending, 3);
        event_in = 1; tick();
        checkVal("coinc_pend_after", pending, 3);
        waitIdle("coinc_drain", 200);

        // Busy stuck after accept
        busyLen = 40;
        event_in = 1; tick();
        waitFlag("stuck", 20);
        n = 0;
        while (!timeout_err && n < 30) begin tick(); n++; end
        checkVal("stuck_cycles", n, 10);
        checkVal("stuck_err", timeout_err, 1);
        checkVal("stuck_idle", idle, 1);
        event_in = 1; tick();
        bad = 0; n = 0;
        while (busy_in && n < 60) begin if (flag_out) bad++; tick(); n++; end
        checkVal("stuck_no_flag_while_busy", bad, 0);
        clr_err = 1; tick();
        checkVal("stuck_err_cleared", timeout_err, 0);
        n = 0;
        while (!willTimeout() && n < 60) begin tick(); n++; end
        if (n >= 60) checkVal("stuck2_wait_expired", 0, 1);
        clr_err = 1; tick();
        checkVal("stuck2_clr_coincident", timeout_err, 1);
        busyLen = 6;
        clr_err = 1; tick();
        waitIdle("stuck_drain", 200);

        // Reset during WAIT_LO with 4 pending
        forceBusy = 1; tick();
        for (int i = 0; i < 5; i++) begin event_in = 1; tick(); end
        forceBusy = 0; tick();
        n = 0;
        while (!(mHs && mSaw && !mFlag) && n < 30) begin tick(); n++; end
        if (n >= 30) checkVal("rstmid_wait_expired", 0, 1);
        checkVal("rstmid_pend_before", pending, 4);
        rst = 1; busyLeft = 0; tick();
        checkVal("rstmid_pending", pending, 0);
        checkVal("rstmid_flag", flag_out, 0);
        checkVal("rstmid_idle", idle, 1);
        checkVal("rstmid_overflow", overflow, 0);
        checkVal("rstmid_timeout", timeout_err, 0);

        // Randomized traffic
        busyLen = 0;
        for (int i = 0; i < 2500; i++) begin
            event_in = ($urandom_range(0, 2) == 0);
            clr_err  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 80) == 0) forceBusy = !forceBusy;
            if ($urandom_range(0, 600) == 0) begin rst = 1; busyLeft = 0; end
            tick();
        end
        forceBusy = 0; busyLen = 6;
        tick();
        waitIdle("random_drain", 600);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
